mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Shares one pipelined W×W multiplier between N requesting solver cores (e.g. sum-of-squares and square-of-sum engines), so problem modules no longer each infer their own multiplier. Round-robin arbitration, one multiply accepted per cycle, at most one outstanding operation per requester, results returned on a shared bus with a one-hot acknowledge. It sits between the problem cores and the single multiplier resource, inside each problem top.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- W, 32, operand width
- LAT, 2, multiplier pipeline depth in cycles (1..4)

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- req  input  N  per-requester request, level
- a_flat  input  N*W  operand A, requester i at bits [i*W +: W]
- b_flat  input  N*W  operand B, same packing
- gnt  output  N  one-hot, combinational; operands of granted requester captured at this edge
- ack  output  N  one-hot registered pulse, result for that requester valid on prod
- prod  output  2W  full product, valid only while ack nonzero
- ovf  output  1  upper W bits of prod nonzero (see Configuration)
- idle  output  1  no operation in flight and no pending bits set

## Operation
- State: rr_ptr (log2 N bits), pending[N], pipeline stages each holding valid, one-hot tag, a×b partial/result.
- Eligible = req & ~pending. If eligible nonzero: gnt = first eligible bit searching from rr_ptr upward, wrapping at N-1→0. Otherwise gnt = 0.
- On granted edge: operands of winner enter stage 0 with tag = gnt; pending[winner] set; rr_ptr ← winner+1 mod N. No grant: rr_ptr holds, bubble enters pipeline.
- Stage LAT output: ack ← tag when valid, prod ← full 2W product (unsigned, no truncation); pending[tag] cleared at the edge ending the ack cycle.
- Requester holding req high after gnt is not re-granted until the cycle after its ack.
- Requester may drop req before gnt without side effects; operands are only sampled on the grant edge.
- ack/prod/ovf are 0 whenever no result is retiring.

## Timing
- Reset values: gnt 0 (pending 0, req low), ack 0, prod 0, ovf 0, idle 1, rr_ptr 0, all stage valids 0.
- Grant in cycle c → ack in cycle c+LAT, fixed latency, no stalls, no backpressure on ack.
- Throughput one accepted multiply per cycle across requesters; per requester one per LAT+1 cycles max.
- ack for requester i in cycle d with req[i] high: earliest re-grant of i is cycle d+1.
- Simultaneous requests: exactly one gnt per cycle, order strictly rotates from rr_ptr.
- rst asserted mid-operation: in-flight operations discarded, no ack emitted for them, pending cleared, next cycle behaves as post-reset.
- N=1 degenerate: rr_ptr unused, grant whenever req & ~pending.

## Configuration
- MUL_ARB_OVF_EN defined: ovf registered alongside ack, 1 when prod[2W-1:W] ≠ 0 for the retiring result, 0 otherwise.
- Not defined: ovf tied to 0, no overflow compare logic synthesized; all other behaviour identical.

## Test plan
- Single request: N=4, LAT=2, req=0001, a=100, b=100 in cycle 0 → gnt=0001 cycle 0, ack=0001 cycle 2, prod=10000, idle returns 1 cycle 3.
- All four request every cycle with distinct operands → grants rotate 0001,0010,0100,1000 for cycles 0-3, each requester re-granted no earlier than cycle after its ack; every prod matches a×b.
- Held req: req[2] high continuously from cycle 0 alone → grants at cycles 0,3,6,… (LAT=2), acks at 2,5,8,….
- Overflow: a=b=0x0001_0000 with MUL_ARB_OVF_EN → prod=0x1_0000_0000, ovf=1; a=b=5050 → prod=25502500, ovf=0; without macro ovf=0 both.
- Reset mid-flight: grant cycle 0, rst high cycle 1 → no ack at cycle 2, pending 0, idle=1, rr_ptr=0 after reset.
- Fairness under starvation pressure: req=1111 held 40 cycles → each bit granted 10±1 times, no two gnt bits ever high together.

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter: several requesters share one pipelined W x W unsigned multiplier.
//
// Arbitration is round-robin and combinational. The operands of the granted
// requester are captured at the grant edge. The full 2W-bit product comes back
// LAT cycles later on a shared bus, together with a one-hot ack. Each requester
// can have at most one operation outstanding: its pending bit masks it from
// arbitration until the edge that ends its ack cycle.
//
// Parameters:
//   N    number of requesters (2..8; N=1 also works)
//   W    operand width
//   LAT  pipeline depth in cycles (1..4)
//
// Ports:
//   clk     clock, posedge
//   rst     synchronous active-high reset
//   req     per-requester request level
//   a_flat  operand A, requester i at [i*W +: W]
//   b_flat  operand B, same packing
//   gnt     one-hot grant (combinational)
//   ack     one-hot result strobe, registered
//   prod    full 2W-bit product, 0 when ack is 0
//   ovf     upper W bits of prod nonzero (only when MUL_ARB_OVF_EN is defined)
//   idle    nothing pending and nothing in flight
//
// Optional feature: define MUL_ARB_OVF_EN to enable the registered overflow
// flag. Without it, ovf is tied to 0.
module mul_arbiter #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [2*W-1:0] prod,
  output logic           ovf,
  output logic           idle
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  rr_nxt;
  logic [N-1:0]   pending;
  logic [N-1:0]   elig;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;

  logic [LAT-1:0] vld_p;
  logic [N-1:0]   tag_p  [LAT];
  logic [2*W-1:0] prod_p [LAT];

  function automatic logic [2*W-1:0] mul_full(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  assign elig = req & ~pending;

  // Search upward from rr_ptr and wrap at N-1. The pointer moves to one past
  // the winner, so the winner has the lowest priority next time.
  always_comb begin
    int   idx;
    logic found;
    gnt    = '0;
    rr_nxt = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && elig[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        rr_nxt   = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // gnt is one-hot, so an AND-OR mux is enough to select the operands.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      a_sel = a_sel | (a_flat[i*W +: W] & {W{gnt[i]}});
      b_sel = b_sel | (b_flat[i*W +: W] & {W{gnt[i]}});
    end
  end

  // A requester cannot be granted and acked in the same cycle: a grant needs
  // pending clear, and an ack implies pending set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      rr_ptr  <= '0;
      vld_p   <= '0;
    end else begin
      pending  <= (pending | gnt) & ~ack;
      rr_ptr   <= rr_nxt;
      vld_p[0] <= |gnt;
      for (int s = 1; s < LAT; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // Stage 0: capture the tag and product of the granted requester.
  // Stages 1..LAT-1: delay line; the last stage drives the result bus.
  always_ff @(posedge clk) begin
    tag_p[0]  <= gnt;
    prod_p[0] <= mul_full(a_sel, b_sel);
    for (int s = 1; s < LAT; s++) begin
      tag_p[s]  <= tag_p[s-1];
      prod_p[s] <= prod_p[s-1];
    end
  end

  // Data registers have no reset, so the last-stage valid gates the result
  // bus to zero.
  assign ack  = vld_p[LAT-1] ? tag_p[LAT-1]  : '0;
  assign prod = vld_p[LAT-1] ? prod_p[LAT-1] : '0;
  assign idle = (pending == '0) && (vld_p == '0);

`ifdef MUL_ARB_OVF_EN
  function automatic logic hi_nonzero(input logic [2*W-1:0] p);
    return |p[2*W-1:W];
  endfunction

  logic [LAT-1:0] ovf_p;

  // The overflow flag travels with its product through the same stages.
  always_ff @(posedge clk) begin
    ovf_p[0] <= hi_nonzero(mul_full(a_sel, b_sel));
    for (int s = 1; s < LAT; s++) ovf_p[s] <= ovf_p[s-1];
  end

  assign ovf = vld_p[LAT-1] & ovf_p[LAT-1];
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 2;
`ifdef MUL_ARB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_flat, b_flat;
  logic [N-1:0]   gnt, ack;
  logic [2*W-1:0] prod;
  logic           ovf, idle;

  always #5 clk = ~clk;

  mul_arbiter #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .ack(ack), .prod(prod), .ovf(ovf), .idle(idle)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int             due;
    logic [N-1:0]   tag;
    logic [2*W-1:0] p;
    logic           o;
  } exp_t;
  exp_t sbq[$];

  logic [N-1:0]   tb_pend = '0;
  logic [N-1:0]   gnt_log  [0:1023];
  logic [N-1:0]   ack_log  [0:1023];
  logic [2*W-1:0] prod_log [0:1023];
  logic           ovf_log  [0:1023];
  logic           idle_log [0:1023];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and scoreboard. Grants push expected results; retiring results pop.
  always @(negedge clk) begin
    logic [N-1:0]   exp_ack;
    logic [2*W-1:0] exp_p;
    logic           exp_o;
    logic [2*W-1:0] pr;
    exp_t           e;
    if (mon_en) begin
      if (cyc < 1024) begin
        gnt_log[cyc]  = gnt;
        ack_log[cyc]  = ack;
        prod_log[cyc] = prod;
        ovf_log[cyc]  = ovf;
        idle_log[cyc] = idle;
      end
      exp_ack = '0; exp_p = '0; exp_o = 1'b0;
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_ack = sbq[0].tag;
        exp_p   = sbq[0].p;
        exp_o   = sbq[0].o;
        void'(sbq.pop_front());
      end
      chk("ack", 64'(ack), 64'(exp_ack));
      chk("prod", prod, exp_p);
      chk("ovf", 64'(ovf), 64'(exp_o));
      chk("idle", 64'(idle), 64'(tb_pend == '0));
      if (!rst) begin
        if (gnt != '0) begin
          chk("gnt_onehot", 64'($onehot(gnt)), 64'd1);
          chk("gnt_eligible", 64'(gnt & ~(req & ~tb_pend)), 64'd0);
          for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
              pr    = {{W{1'b0}}, a_flat[i*W +: W]} * {{W{1'b0}}, b_flat[i*W +: W]};
              e.due = cyc + LAT;
              e.tag = '0;
              e.tag[i] = 1'b1;
              e.p   = pr;
              e.o   = OVF_ON && (pr[2*W-1:W] != '0);
              sbq.push_back(e);
            end
          end
          tb_pend = tb_pend | gnt;
        end else begin
          chk("gnt_missing", 64'(req & ~tb_pend), 64'd0);
        end
        tb_pend = tb_pend & ~exp_ack;
      end else begin
        sbq.delete();
        tb_pend = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && !idle; i++) step();
    chk("idle_timeout", 64'(idle), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int c0;
    int cnt [N];
    logic [N-1:0] rot [4];
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000;
    rst = 1'b1; req = '0; a_flat = '0; b_flat = '0;

    // Reset state
    step();
    mon_en = 1'b1;
    step();
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_prod", prod, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_gnt", 64'(gnt), 64'd0);
    rst = 1'b0;
    step();

    // Single request: 100 x 100
    set_ops(0, 32'd100, 32'd100);
    req = 4'b0001;
    c0 = cyc;
    step();
    req = '0;
    repeat (4) step();
    chk("t1_gnt", 64'(gnt_log[c0]), 64'h1);
    chk("t1_ack", 64'(ack_log[c0+2]), 64'h1);
    chk("t1_ack_early", 64'(ack_log[c0+1]), 64'h0);
    chk("t1_prod", prod_log[c0+2], 64'd10000);
    chk("t1_idle_busy", 64'(idle_log[c0+2]), 64'd0);
    chk("t1_idle_back", 64'(idle_log[c0+3]), 64'd1);

    // All four request continuously with distinct operands
    do_reset();
    step();
    set_ops(0, 32'd3, 32'd5);
    set_ops(1, 32'd7, 32'd11);
    set_ops(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_ops(3, 32'h0001_0000, 32'h0001_0000);
    req = 4'b1111;
    c0 = cyc;
    repeat (12) step();
    req = '0;
    wait_idle();
    for (int k = 0; k < 8; k++) chk("t2_rotate", 64'(gnt_log[c0+k]), 64'(rot[k%4]));
    chk("t2_prod0", prod_log[c0+2], 64'd15);
    chk("t2_prod1", prod_log[c0+3], 64'd77);
    chk("t2_prod2", prod_log[c0+4], 64'hFFFF_FFFE_0000_0001);
    chk("t2_prod3", prod_log[c0+5], 64'h0000_0001_0000_0000);
    chk("t2_ovf3", 64'(ovf_log[c0+5]), 64'(OVF_ON));
    chk("t2_ovf0", 64'(ovf_log[c0+2]), 64'd0);

    // Held request on requester 2 alone: 5050 x 5050
    do_reset();
    step();
    set_ops(2, 32'd5050, 32'd5050);
    req = 4'b0100;
    c0 = cyc;
    repeat (11) step();
    req = '0;
    wait_idle();
    for (int k = 0; k < 10; k++)
      chk("t3_gnt", 64'(gnt_log[c0+k]), (k % 3 == 0) ? 64'h4 : 64'h0);
    for (int k = 0; k < 9; k++)
      chk("t3_ack", 64'(ack_log[c0+k]), (k % 3 == 2) ? 64'h4 : 64'h0);
    chk("t3_prod", prod_log[c0+2], 64'd25502500);
    chk("t3_ovf", 64'(ovf_log[c0+2]), 64'd0);

    // Reset mid-flight, then fairness with all four held for 40 cycles
    step();
    set_ops(0, 32'd9, 32'd9);
    req = 4'b0001;
    c0 = cyc;
    step();
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0;
    step();
    req = 4'b1111;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    repeat (40) step();
    req = '0;
    wait_idle();
    chk("t4_gnt", 64'(gnt_log[c0]), 64'h1);
    chk("t4_no_ack", 64'(ack_log[c0+2]), 64'h0);
    chk("t4_idle", 64'(idle_log[c0+2]), 64'd1);
    chk("t4_rr_reset", 64'(gnt_log[c0+3]), 64'h1);
    for (int k = 0; k < 40; k++)
      for (int i = 0; i < N; i++)
        if (gnt_log[c0+3+k][i]) cnt[i]++;
    for (int i = 0; i < N; i++)
      chk("t5_fair", 64'(cnt[i] >= 9 && cnt[i] <= 11), 64'd1);
    chk("t5_sb_empty", 64'(sbq.size()), 64'd0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
